// File: rtl/cpm_clk_switch_ctl.sv
// Glitch-free sequencer that applies cpm_clock_ctl_reg writes to the CPM divider/gate.
// Optional one-entry pending buffer for writes arriving while busy: define CPM_CLK_CTL_PEND_EN.
module cpm_clk_switch_ctl #(
  parameter int DRAIN_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic        CRCU_CLK,
  input  logic        CRCU_RST_N,
  input  logic        cfg_wr,
  input  logic [31:0] cfg_data,
  output logic        cfg_ready,
  output logic [2:0]  div_sel,
  output logic        div_clk_en,
  output logic [4:0]  cur_cfg,
  output logic        busy,
  output logic        done,
  output logic        sel_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWITCH,
    ST_SETTLE,
    ST_APPLY
  } state_e;

  localparam int MAX_CYCLES = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       pend_q, pend_d;
  logic [2:0]       div_sel_q, div_sel_d;
  logic             div_clk_en_q, div_clk_en_d;
  logic [4:0]       cur_cfg_q, cur_cfg_d;
  logic             done_q, done_d;
  logic             sel_err_q, sel_err_d;

  logic             start;
  logic [4:0]       start_cfg;

  wire unused_cfg_bits = ^cfg_data[31:5];

`ifdef CPM_CLK_CTL_PEND_EN
  logic       buf_valid_q, buf_valid_d;
  logic [4:0] buf_cfg_q, buf_cfg_d;

  // A live write in IDLE takes precedence over (and discards) the buffered one.
  always_comb begin
    start       = 1'b0;
    start_cfg   = cfg_data[4:0];
    buf_valid_d = buf_valid_q;
    buf_cfg_d   = buf_cfg_q;
    if (state_q == ST_IDLE) begin
      if (cfg_wr) begin
        start       = 1'b1;
        buf_valid_d = 1'b0;
      end else if (buf_valid_q) begin
        start       = 1'b1;
        start_cfg   = buf_cfg_q;
        buf_valid_d = 1'b0;
      end
    end else if (cfg_wr) begin
      buf_valid_d = 1'b1;
      buf_cfg_d   = cfg_data[4:0];
    end
  end

  always_ff @(posedge CRCU_CLK) begin
    if (!CRCU_RST_N) begin
      buf_valid_q <= 1'b0;
      buf_cfg_q   <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_cfg_q   <= buf_cfg_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE) || !buf_valid_q;
`else
  assign start     = (state_q == ST_IDLE) && cfg_wr;
  assign start_cfg = cfg_data[4:0];
  assign cfg_ready = (state_q == ST_IDLE);
`endif

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    div_sel_d    = div_sel_q;
    div_clk_en_d = div_clk_en_q;
    cur_cfg_d    = cur_cfg_q;
    done_d       = 1'b0;
    sel_err_d    = sel_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pend_d = start_cfg;
          if (start_cfg[2:0] > 3'd3) begin
            sel_err_d = 1'b1;
            done_d    = 1'b1;
          end else if (start_cfg[2:0] == div_sel_q) begin
            sel_err_d = 1'b0;
            state_d   = ST_APPLY;
          end else begin
            sel_err_d    = 1'b0;
            div_clk_en_d = 1'b0;
            cnt_d        = DRAIN_LOAD;
            state_d      = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        div_clk_en_d = 1'b0;
        if (cnt_q == '0) state_d = ST_SWITCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_SWITCH: begin
        div_sel_d = pend_q[2:0];
        cnt_d     = SETTLE_LOAD;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        div_clk_en_d = 1'b0;
        if (cnt_q == '0) begin
          state_d      = ST_IDLE;
          cur_cfg_d    = pend_q;
          div_clk_en_d = pend_q[3] & ~pend_q[4];
          done_d       = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_APPLY: begin
        state_d      = ST_IDLE;
        cur_cfg_d    = pend_q;
        div_clk_en_d = pend_q[3] & ~pend_q[4];
        done_d       = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CRCU_CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!CRCU_RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      pend_q       <= '0;
      div_sel_q    <= '0;
      div_clk_en_q <= 1'b0;
      cur_cfg_q    <= '0;
      done_q       <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      div_sel_q    <= div_sel_d;
      div_clk_en_q <= div_clk_en_d;
      cur_cfg_q    <= cur_cfg_d;
      done_q       <= done_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign div_sel    = div_sel_q;
  assign div_clk_en = div_clk_en_q;
  assign cur_cfg    = cur_cfg_q;
  assign done       = done_q;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_cpm_clk_switch_ctl.sv
// Self-checking bench for cpm_clk_switch_ctl: directed test-plan steps followed by
// random writes/resets, compared every cycle against an event-schedule reference model.
`timescale 1ns/1ps
module tb_cpm_clk_switch_ctl;

  localparam int D = 4;
  localparam int S = 8;

  logic        CRCU_CLK;
  logic        CRCU_RST_N;
  logic        cfg_wr;
  logic [31:0] cfg_data;
  logic        cfg_ready;
  logic [2:0]  div_sel;
  logic        div_clk_en;
  logic [4:0]  cur_cfg;
  logic        busy;
  logic        done;
  logic        sel_err;

  cpm_clk_switch_ctl #(.DRAIN_CYCLES(D), .SETTLE_CYCLES(S)) dut (
    .CRCU_CLK   (CRCU_CLK),
    .CRCU_RST_N (CRCU_RST_N),
    .cfg_wr     (cfg_wr),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .div_sel    (div_sel),
    .div_clk_en (div_clk_en),
    .cur_cfg    (cur_cfg),
    .busy       (busy),
    .done       (done),
    .sel_err    (sel_err)
  );

  initial CRCU_CLK = 1'b0;
  always #5 CRCU_CLK = ~CRCU_CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: each accepted write schedules the edge at which the divider
  // select changes and the edge at which the sequence completes.
  int         cyc = 0;
  bit         m_active = 0;
  int         m_sel_at = -1;
  int         m_end = -1;
  logic [4:0] m_new = '0;
  logic [2:0] m_sel = '0;
  logic       m_en = 1'b0;
  logic [4:0] m_cur = '0;
  logic       m_err = 1'b0;
  logic       m_done = 1'b0;
  bit         m_bv = 0;
  logic [4:0] m_bcfg = '0;

  logic [2:0] prev_sel = '0;
  logic       prev_en = 1'b0;
  int         done_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input logic wr, input logic [31:0] data, input logic rst_n);
    bit         have;
    logic [4:0] cfg;
    cyc++;
    m_done = 1'b0;
    if (!rst_n) begin
      m_active = 0; m_sel_at = -1; m_end = -1; m_new = '0;
      m_sel = '0; m_en = 1'b0; m_cur = '0; m_err = 1'b0; m_bv = 0; m_bcfg = '0;
      return;
    end
    if (m_active) begin
      if (cyc == m_sel_at) m_sel = m_new[2:0];
      if (cyc == m_end) begin
        m_cur    = m_new;
        m_en     = m_new[3] & !m_new[4];
        m_done   = 1'b1;
        m_active = 0;
      end
`ifdef CPM_CLK_CTL_PEND_EN
      if (wr) begin m_bv = 1; m_bcfg = data[4:0]; end
`endif
    end else begin
      have = wr;
      cfg  = data[4:0];
`ifdef CPM_CLK_CTL_PEND_EN
      if (!wr && m_bv) begin have = 1; cfg = m_bcfg; end
      if (have) m_bv = 0;
`endif
      if (have) begin
        if (cfg[2:0] > 3) begin
          m_err  = 1'b1;
          m_done = 1'b1;
        end else if (cfg[2:0] == m_sel) begin
          m_err = 1'b0; m_new = cfg; m_active = 1;
          m_sel_at = -1; m_end = cyc + 1;
        end else begin
          m_err = 1'b0; m_new = cfg; m_active = 1; m_en = 1'b0;
          m_sel_at = cyc + D + 1; m_end = cyc + D + S + 1;
        end
      end
    end
  endtask

  task automatic check_all(input logic rst_n);
    logic exp_ready;
`ifdef CPM_CLK_CTL_PEND_EN
    exp_ready = !m_active || !m_bv;
`else
    exp_ready = !m_active;
`endif
    check("div_sel", 32'(div_sel), 32'(m_sel));
    check("div_clk_en", 32'(div_clk_en), 32'(m_en));
    check("cur_cfg", 32'(cur_cfg), 32'(m_cur));
    check("done", 32'(done), 32'(m_done));
    check("sel_err", 32'(sel_err), 32'(m_err));
    check("busy", 32'(busy), 32'(m_active));
    check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
    if (rst_n)
      check("sel_change_while_enabled", 32'((div_sel !== prev_sel) && prev_en), 32'd0);
    prev_sel = div_sel;
    prev_en  = div_clk_en;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic tick(input logic wr, input logic [31:0] data, input logic rst_n);
    cfg_wr     = wr;
    cfg_data   = data;
    CRCU_RST_N = rst_n;
    @(posedge CRCU_CLK);
    #1;
    model_edge(wr, data, rst_n);
    check_all(rst_n);
    cfg_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    cfg_wr     = 1'b0;
    cfg_data   = '0;
    CRCU_RST_N = 1'b0;

    // Reset values.
    tick(1'b0, 32'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    idle(1);

    // Full path to sel=1, enabled.
    tick(1'b1, 32'h0000_0009, 1'b1);
    idle(D + S + 2);
    check("t1_cur_cfg", 32'(cur_cfg), 32'h09);

    // Same select, gate bit set: apply path, clock disabled.
    tick(1'b1, 32'hFFFF_FF19, 1'b1);
    idle(3);
    check("t2_div_sel", 32'(div_sel), 32'd1);

    // Rejected select, then a valid write clears the sticky error.
    tick(1'b1, 32'h0000_000D, 1'b1);
    check("t3_sel_err", 32'(sel_err), 32'd1);
    idle(2);
    tick(1'b1, 32'h0000_0008, 1'b1);
    idle(D + S + 2);
    check("t3_sel_err_clear", 32'(sel_err), 32'd0);

    // Writes while busy.
    done_seen = 0;
    tick(1'b1, 32'h0000_000A, 1'b1);
    idle(2);
    tick(1'b1, 32'h0000_000B, 1'b1);
    idle(1);
    tick(1'b1, 32'h0000_0008, 1'b1);
    idle(2 * (D + S) + 8);
`ifdef CPM_CLK_CTL_PEND_EN
    check("t4_done_count", 32'(done_seen), 32'd2);
    check("t4_final_sel", 32'(div_sel), 32'd0);
`else
    check("t4_done_count", 32'(done_seen), 32'd1);
    check("t4_final_sel", 32'(div_sel), 32'd2);
`endif

    // Reset pulse during SETTLE.
    tick(1'b1, 32'h0000_0009, 1'b1);
    idle(D + 4);
    check("t5_in_settle", 32'(busy), 32'd1);
    tick(1'b0, 32'h0, 1'b0);
    check("t5_rst_div_sel", 32'(div_sel), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    idle(3);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] d;
      logic        w;
      logic        r;
      d      = $urandom;
      d[2:0] = 3'($urandom_range(0, 5));
      w      = ($urandom_range(0, 3) == 0);
      r      = ($urandom_range(0, 199) != 0);
      tick(w, d, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
